// File: rtl/stickit_scan_decoder.sv
// Purpose: rebuilds the 32-bit hex value shown on a Charlieplexed 8-digit LED scan from sampled drive-enable/level pairs.
// Latency: a word sampled on an EN edge is classified on the next CLK edge; VALUE/VALID follow the digit-7 sample by one edge.
// Backpressure: none; EN is a sample strobe and EN=0 cycles simply hold all state.
module stickit_scan_decoder #(
  parameter int LOCK_FRAMES = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  input  logic [7:0]  S_OE,
  input  logic [7:0]  S_O,
  output logic [31:0] VALUE,
  output logic        VALID,
  output logic        LOCKED,
  output logic        DIGIT_ERR
);

  // Good-frame counter is 4 bits wide, enough for the 1..15 range.
  localparam logic [3:0] LOCK_N = 4'(LOCK_FRAMES);

  typedef enum logic {
    HUNT  = 1'b0,
    TRACK = 1'b1
  } state_t;

  // ---------------------------------------------------------------------
  // Stage 1: sampled scan word
  // ---------------------------------------------------------------------
  logic       smp_vld;
  logic [7:0] smp_oe;
  logic [7:0] smp_o;

  // Capture the scan lines on strobe edges; smp_vld marks a word awaiting stage 2.
  always_ff @(posedge CLK) begin
    if (RST) begin
      smp_vld <= 1'b0;
      smp_oe  <= '0;
      smp_o   <= '0;
    end else begin
      smp_vld <= EN;
      if (EN) begin
        smp_oe <= S_OE;
        smp_o  <= S_O;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 classification (combinational on the sampled word)
  // ---------------------------------------------------------------------
  logic [7:0] anode;
  logic [7:0] seg_on;
  logic [3:0] anode_cnt;
  logic       one_anode;
  logic [2:0] k;
  logic [6:0] mask;
  logic       lut_hit;
  logic [3:0] nib;
  logic       word_ok;

  // Per-line class: driven high is the anode, driven low is a lit segment, released is off.
  always_comb begin
    anode     = smp_oe & smp_o;
    seg_on    = smp_oe & ~smp_o;
    anode_cnt = 4'($countones(anode));
    one_anode = (anode_cnt == 4'd1);
  end

  // Index of the anode line; only meaningful when exactly one anode exists.
  always_comb begin
    k = '0;
    for (int i = 0; i < 8; i++) begin
      if (anode[i]) k = 3'(i);
    end
  end

  // Drop the anode line and close the gap so the remaining seven lines form the segment mask.
  always_comb begin
    mask = '0;
    for (int j = 0; j < 7; j++) begin
      mask[j] = (3'(j) < k) ? seg_on[j] : seg_on[j+1];
    end
  end

  // Seven-segment pattern to hex nibble; anything outside the 16 glyphs is a pattern error.
  always_comb begin
    lut_hit = 1'b1;
    nib     = 4'h0;
    case (mask)
      7'h3F: nib = 4'h0;
      7'h06: nib = 4'h1;
      7'h5B: nib = 4'h2;
      7'h4F: nib = 4'h3;
      7'h66: nib = 4'h4;
      7'h6D: nib = 4'h5;
      7'h7D: nib = 4'h6;
      7'h07: nib = 4'h7;
      7'h7F: nib = 4'h8;
      7'h6F: nib = 4'h9;
      7'h77: nib = 4'hA;
      7'h7C: nib = 4'hB;
      7'h39: nib = 4'hC;
      7'h5E: nib = 4'hD;
      7'h79: nib = 4'hE;
      7'h71: nib = 4'hF;
      default: begin
        lut_hit = 1'b0;
        nib     = 4'h0;
      end
    endcase
  end

  // A word is usable only when it names a single digit and shows a known glyph.
  always_comb begin
    word_ok = one_anode & lut_hit;
  end

  // ---------------------------------------------------------------------
  // Frame tracking FSM
  // ---------------------------------------------------------------------
  state_t      state,     state_nxt;
  logic [2:0]  expected,  expected_nxt;
  logic [27:0] shadow,    shadow_nxt;
  logic [3:0]  good_cnt,  good_cnt_nxt;
  logic [3:0]  cnt_sat;
  logic [31:0] value_nxt;
  logic        valid_nxt;
  logic        locked_nxt;
  logic        err_nxt;

  // State, frame shadow and registered outputs; reset discards any partial frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= HUNT;
      expected  <= '0;
      shadow    <= '0;
      good_cnt  <= '0;
      VALUE     <= '0;
      VALID     <= 1'b0;
      LOCKED    <= 1'b0;
      DIGIT_ERR <= 1'b0;
    end else begin
      state     <= state_nxt;
      expected  <= expected_nxt;
      shadow    <= shadow_nxt;
      good_cnt  <= good_cnt_nxt;
      VALUE     <= value_nxt;
      VALID     <= valid_nxt;
      LOCKED    <= locked_nxt;
      DIGIT_ERR <= err_nxt;
    end
  end

  // Good-frame count after this frame completes, saturating at the lock threshold.
  always_comb begin
    cnt_sat = (good_cnt >= LOCK_N) ? LOCK_N : good_cnt + 4'd1;
  end

  // Next-state and output decode; VALID and DIGIT_ERR come from exclusive branches so never coincide.
  always_comb begin
    state_nxt    = state;
    expected_nxt = expected;
    shadow_nxt   = shadow;
    good_cnt_nxt = good_cnt;
    value_nxt    = VALUE;
    valid_nxt    = 1'b0;
    locked_nxt   = LOCKED;
    err_nxt      = 1'b0;

    if (smp_vld) begin
      case (state)
        HUNT: begin
          // Only a clean digit-0 word can start a frame; everything else is silently skipped.
          if (word_ok && (k == 3'd0)) begin
            shadow_nxt[3:0] = nib;
            expected_nxt    = 3'd1;
            state_nxt       = TRACK;
          end
        end

        TRACK: begin
          if (word_ok && (k == expected)) begin
            for (int i = 0; i < 7; i++) begin
              if (k == 3'(i)) shadow_nxt[4*i +: 4] = nib;
            end
            expected_nxt = expected + 3'd1;
            if (k == 3'd7) begin
              good_cnt_nxt = cnt_sat;
              if (cnt_sat >= LOCK_N) begin
                value_nxt  = {nib, shadow};
                valid_nxt  = 1'b1;
                locked_nxt = 1'b1;
              end
            end
          end else begin
            // The rejected word is consumed here; it never doubles as a new frame start.
            err_nxt      = 1'b1;
            locked_nxt   = 1'b0;
            good_cnt_nxt = '0;
            expected_nxt = '0;
            state_nxt    = HUNT;
          end
        end

        default: begin
          state_nxt = HUNT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stickit_scan_decoder.sv
// Bench for stickit_scan_decoder: scoreboard of expected per-word outputs against recorded DUT outputs.
// Words are driven #1 after the rising edge; outputs are recorded on the falling edge after processing.
// Every EN=1 word yields one expected record and one observed record.
module tb_stickit_scan_decoder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        EN  = 1'b0;
  logic [7:0]  S_OE = '0;
  logic [7:0]  S_O  = '0;
  logic [31:0] VALUE;
  logic        VALID;
  logic        LOCKED;
  logic        DIGIT_ERR;

  typedef struct packed {
    logic        valid;
    logic        err;
    logic        locked;
    logic [31:0] value;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  int   vecs  = 0;
  int   fails = 0;
  int   gap   = 0;
  logic en_d1 = 1'b0;
  logic en_d2 = 1'b0;

  logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  always #5 CLK = ~CLK;

  stickit_scan_decoder #(.LOCK_FRAMES(2)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .EN        (EN),
    .S_OE      (S_OE),
    .S_O       (S_O),
    .VALUE     (VALUE),
    .VALID     (VALID),
    .LOCKED    (LOCKED),
    .DIGIT_ERR (DIGIT_ERR)
  );

  // Track which edges processed a sampled word.
  always @(posedge CLK) begin
    en_d1 <= EN;
    en_d2 <= en_d1;
  end

  // Record DUT outputs one edge after each sampled word.
  always @(negedge CLK) begin
    if (en_d2) obs_q.push_back({VALID, DIGIT_ERR, LOCKED, VALUE});
  end

  task automatic drive(input logic en, input logic [7:0] oe, input logic [7:0] o);
    EN   = en;
    S_OE = oe;
    S_O  = o;
    @(posedge CLK);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 8'($urandom), 8'($urandom));
  endtask

  // Build the scan word for digit d showing nibble n.
  task automatic enc(input int d, input logic [3:0] n, output logic [7:0] oe, output logic [7:0] o);
    logic [6:0] m;
    int j;
    m = seg_tab[n];
    for (int i = 0; i < 8; i++) begin
      if (i == d) begin
        oe[i] = 1'b1;
        o[i]  = 1'b1;
      end else begin
        j = (i < d) ? i : i - 1;
        if (m[j]) begin
          oe[i] = 1'b1;
          o[i]  = 1'b0;
        end else begin
          oe[i] = 1'b0;
          o[i]  = 1'($urandom);
        end
      end
    end
  endtask

  task automatic send_word(input logic [7:0] oe, input logic [7:0] o, input rec_t r);
    exp_q.push_back(r);
    drive(1'b1, oe, o);
    if (gap > 0) idle(gap);
  endtask

  task automatic send_digit(input int d, input logic [3:0] n, input rec_t r);
    logic [7:0] oe;
    logic [7:0] o;
    enc(d, n, oe, o);
    send_word(oe, o, r);
  endtask

  function automatic rec_t mk(input logic v, input logic e, input logic l, input logic [31:0] val);
    rec_t r;
    r.valid  = v;
    r.err    = e;
    r.locked = l;
    r.value  = val;
    return r;
  endfunction

  // Send digits start..7 of v; lock_end says whether digit 7 should publish v.
  task automatic send_frame(input logic [31:0] v, input int start, input logic lock_end,
                            input logic lk_before, input logic [31:0] val_before);
    rec_t r;
    for (int d = start; d < 8; d++) begin
      if (d == 7 && lock_end) r = mk(1'b1, 1'b0, 1'b1, v);
      else                    r = mk(1'b0, 1'b0, lk_before, val_before);
      send_digit(d, v[4*d +: 4], r);
    end
  endtask

  task automatic do_reset();
    idle(2);
    RST = 1'b1;
    idle(1);
    RST = 1'b0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic test_reset();
    vecs++;
    if (VALUE !== 32'h0) begin fails++; $display("FAIL reset VALUE: got %h, expected 00000000", VALUE); end
    vecs++;
    if (VALID !== 1'b0) begin fails++; $display("FAIL reset VALID: got %b, expected 0", VALID); end
    vecs++;
    if (LOCKED !== 1'b0) begin fails++; $display("FAIL reset LOCKED: got %b, expected 0", LOCKED); end
    vecs++;
    if (DIGIT_ERR !== 1'b0) begin fails++; $display("FAIL reset DIGIT_ERR: got %b, expected 0", DIGIT_ERR); end
    RST = 1'b0;
    idle(2);
  endtask

  task automatic test_clean_lock();
    rec_t e, o;
    int   n = 0;
    send_frame(32'hDEADBEEF, 0, 1'b0, 1'b0, 32'h0);
    send_frame(32'hDEADBEEF, 0, 1'b1, 1'b0, 32'h0);
    send_frame(32'hDEADBEEF, 0, 1'b1, 1'b1, 32'hDEADBEEF);
    idle(3);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL clean_lock word %0d: got vld=%b err=%b lck=%b val=%h, expected vld=%b err=%b lck=%b val=%h",
                 n, o.valid, o.err, o.locked, o.value, e.valid, e.err, e.locked, e.value);
      end
      n++;
    end
  endtask

  task automatic test_mid_start();
    rec_t e, o;
    int   n = 0;
    do_reset();
    send_frame(32'h12345678, 3, 1'b0, 1'b0, 32'h0);
    send_frame(32'h12345678, 0, 1'b0, 1'b0, 32'h0);
    send_frame(32'h12345678, 0, 1'b1, 1'b0, 32'h0);
    send_frame(32'h12345678, 0, 1'b1, 1'b1, 32'h12345678);
    idle(3);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL mid_start word %0d: got vld=%b err=%b lck=%b val=%h, expected vld=%b err=%b lck=%b val=%h",
                 n, o.valid, o.err, o.locked, o.value, e.valid, e.err, e.locked, e.value);
      end
      n++;
    end
  endtask

  task automatic test_bad_pattern();
    rec_t e, o;
    int   n = 0;
    for (int d = 0; d < 4; d++) send_digit(d, 4'(8 - d), mk(1'b0, 1'b0, 1'b1, 32'h12345678));
    send_word(8'h10, 8'h10, mk(1'b0, 1'b1, 1'b0, 32'h12345678));
    send_frame(32'hCAFE0000, 0, 1'b0, 1'b0, 32'h12345678);
    send_frame(32'hCAFE0000, 0, 1'b1, 1'b0, 32'h12345678);
    idle(3);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL bad_pattern word %0d: got vld=%b err=%b lck=%b val=%h, expected vld=%b err=%b lck=%b val=%h",
                 n, o.valid, o.err, o.locked, o.value, e.valid, e.err, e.locked, e.value);
      end
      n++;
    end
  endtask

  task automatic test_anode_faults();
    rec_t e, o;
    int   n = 0;
    logic [31:0] v1 = 32'h89ABCDEF;
    logic [31:0] v2 = 32'h02468ACE;
    // Two anodes (lines 2 and 5) while locked.
    send_digit(0, 4'h0, mk(1'b0, 1'b0, 1'b1, 32'hCAFE0000));
    send_digit(1, 4'h0, mk(1'b0, 1'b0, 1'b1, 32'hCAFE0000));
    send_word(8'h24, 8'h24, mk(1'b0, 1'b1, 1'b0, 32'hCAFE0000));
    send_frame(v1, 0, 1'b0, 1'b0, 32'hCAFE0000);
    send_frame(v1, 0, 1'b1, 1'b0, 32'hCAFE0000);
    // No anode while locked.
    send_word(8'h3F, 8'h00, mk(1'b0, 1'b1, 1'b0, v1));
    send_frame(v1, 0, 1'b0, 1'b0, v1);
    send_frame(v1, 0, 1'b1, 1'b0, v1);
    // Skipped digit: 0, 1, 3.
    send_digit(0, v1[3:0], mk(1'b0, 1'b0, 1'b1, v1));
    send_digit(1, v1[7:4], mk(1'b0, 1'b0, 1'b1, v1));
    send_digit(3, v1[15:12], mk(1'b0, 1'b1, 1'b0, v1));
    // Digit 0 where digit 2 is expected: rejected and not taken as a new start.
    send_digit(0, 4'h5, mk(1'b0, 1'b0, 1'b0, v1));
    send_digit(1, 4'h5, mk(1'b0, 1'b0, 1'b0, v1));
    send_digit(0, 4'h5, mk(1'b0, 1'b1, 1'b0, v1));
    send_frame(v2, 1, 1'b0, 1'b0, v1);
    send_frame(v2, 0, 1'b0, 1'b0, v1);
    send_frame(v2, 0, 1'b1, 1'b0, v1);
    idle(3);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL anode_faults word %0d: got vld=%b err=%b lck=%b val=%h, expected vld=%b err=%b lck=%b val=%h",
                 n, o.valid, o.err, o.locked, o.value, e.valid, e.err, e.locked, e.value);
      end
      n++;
    end
  endtask

  task automatic test_en_gaps();
    rec_t e, o;
    int   n = 0;
    do_reset();
    gap = 3;
    send_frame(32'h0F1E2D3C, 0, 1'b0, 1'b0, 32'h0);
    send_frame(32'h0F1E2D3C, 0, 1'b1, 1'b0, 32'h0);
    send_frame(32'h0F1E2D3C, 0, 1'b1, 1'b1, 32'h0F1E2D3C);
    gap = 0;
    idle(3);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL en_gaps word %0d: got vld=%b err=%b lck=%b val=%h, expected vld=%b err=%b lck=%b val=%h",
                 n, o.valid, o.err, o.locked, o.value, e.valid, e.err, e.locked, e.value);
      end
      n++;
    end
  endtask

  task automatic test_reset_mid_frame();
    rec_t e, o;
    int   n = 0;
    logic [31:0] v = 32'h0F1E2D3C;
    for (int d = 0; d < 6; d++) send_digit(d, v[4*d +: 4], mk(1'b0, 1'b0, 1'b1, v));
    idle(3);
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_mid pre word %0d: got vld=%b err=%b lck=%b val=%h, expected vld=%b err=%b lck=%b val=%h",
                 n, o.valid, o.err, o.locked, o.value, e.valid, e.err, e.locked, e.value);
      end
      n++;
    end
    do_reset();
    vecs++;
    if (VALUE !== 32'h0) begin fails++; $display("FAIL reset_mid VALUE: got %h, expected 00000000", VALUE); end
    vecs++;
    if (LOCKED !== 1'b0) begin fails++; $display("FAIL reset_mid LOCKED: got %b, expected 0", LOCKED); end
    vecs++;
    if (VALID !== 1'b0) begin fails++; $display("FAIL reset_mid VALID: got %b, expected 0", VALID); end
    // Tail of the interrupted frame must not complete anything.
    send_digit(6, v[27:24], mk(1'b0, 1'b0, 1'b0, 32'h0));
    send_digit(7, v[31:28], mk(1'b0, 1'b0, 1'b0, 32'h0));
    send_frame(32'h13579BDF, 0, 1'b0, 1'b0, 32'h0);
    send_frame(32'h13579BDF, 0, 1'b1, 1'b0, 32'h0);
    idle(3);
    n = 0;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      vecs++;
      if (o !== e) begin
        fails++;
        $display("FAIL reset_mid post word %0d: got vld=%b err=%b lck=%b val=%h, expected vld=%b err=%b lck=%b val=%h",
                 n, o.valid, o.err, o.locked, o.value, e.valid, e.err, e.locked, e.value);
      end
      n++;
    end
  endtask

  initial begin
    RST = 1'b1;
    repeat (3) @(posedge CLK);
    #1;
    test_reset();
    test_clean_lock();
    test_mid_start();
    test_bad_pattern();
    test_anode_faults();
    test_en_gaps();
    test_reset_mid_frame();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
